me_best_mv_tracker: RTL and testbench
=====================================

Name: me_best_mv_tracker

Overview:
- Sits downstream of the motion-estimation controller and the SAD processing-element array.
- Consumes the per-candidate SAD stream produced during the serpentine search scan: up-shift, left-shift, down-shift, left-shift.
- Reconstructs each candidate's (x,y) search position from the controller's `sel` move code, keeps the running minimum SAD, and presents the winning motion vector through a valid/ready result handshake.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search window edge in pixels.
- SAD_W, 16, SAD input width; must be at least 16 for a 16x16 block.
- Derived (localparam):
  - SPAN = SEARCH_DIM-MACRO_DIM+1 (33)
  - RANGE = (SEARCH_DIM-MACRO_DIM)/2 (16)
  - NUM_CAND = SPAN*SPAN (1089)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new macroblock search; pulse
- sad_valid  in  1  SAD sample present; driven by the controller's valid
- sel  in  2  move producing this sample: 1=y+1 (up), 0=y-1 (down), 2=x+1 (left), 3=illegal
- sad  in  SAD_W  SAD of current candidate
- busy  out  1  search in progress
- res_valid  out  1  result available
- res_ready  in  1  result consumer accept
- mv_x  out  6  signed motion vector x = best_x-RANGE
- mv_y  out  6  signed motion vector y = best_y-RANGE
- min_sad  out  SAD_W  best SAD
- err  out  1  sticky scan-position error for current search

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On reset:
  - busy=0, res_valid=0, err=0, mv_x=0, mv_y=0, min_sad=all ones.
  - State IDLE; position and sample counters cleared.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - start=1 → SCAN; clears x=0, y=0, cnt=0, best=all ones, err=0.
  - sad_valid is ignored in IDLE, including in the start cycle.
- SCAN (busy=1):
  - Each cycle with sad_valid=1 is one candidate.
  - First sample after start sits at (0,0); sel is ignored for it.
  - Later samples update position before comparing: sel=1 → y+1; sel=0 → y-1; sel=2 → x+1, y unchanged; sel=3 → position unchanged, err set.
  - Move leaving [0,SPAN-1] on either axis: err set, coordinate saturates at the bound.
  - Compare: sad < best → best=sad, best_x/best_y=current position.
  - Ties keep the earlier candidate (see optional feature).
  - cnt increments per sample. When the sample making cnt==NUM_CAND is accepted → HOLD next cycle, with res_valid=1 and outputs loaded from the best registers.
  - Latency: last sample to res_valid is 1 cycle.
  - Cycles with sad_valid=0 hold all state.
- HOLD (busy=0, res_valid=1):
  - mv_x, mv_y, min_sad, err stable until res_valid&res_ready.
  - Handshake accepted → IDLE next cycle, res_valid=0; outputs retain their values.
  - start while in HOLD is ignored. sad_valid while in HOLD is ignored.
- start asserted in SCAN: aborts the current search and restarts as from IDLE; no result is produced for the aborted search.
- rst asserted in any state overrides everything next edge.
- Arithmetic:
  - x, y are 6-bit unsigned.
  - mv = position-RANGE in 6-bit two's complement, range -16..+16.
  - SAD compare is unsigned, full SAD_W width.

Optional Feature:
- Macro: ME_ZERO_BIAS_EN.
- Defined:
  - Ties (sad == best) are resolved toward the candidate with smaller |mv_x|+|mv_y|.
  - A new candidate replaces best only if its L1 distance is strictly smaller.
  - Implementation keeps a 6-bit best_dist register.
- Undefined: strict less-than only; first-found candidate wins ties; no distance logic is synthesized.

Test Plan:
- Full scan, all SAD=1000 except candidate #0 SAD=5 → res_valid one cycle after sample 1089, mv=(-16,-16), min_sad=5, err=0.
- Full serpentine scan (33 up, left, 33 down, left, ...), SAD=0 only at position x=16,y=16 → mv=(0,0), min_sad=0.
- Two equal minima, SAD=7 at (0,0) and at (16,16):
  - Macro off → mv=(-16,-16).
  - ME_ZERO_BIAS_EN on → mv=(0,0).
- sel=3 mid-scan, plus a down move at y=0 → err=1 at result, y stays 0, scan completes normally after 1089 samples.
- Hold res_ready=0 for 20 cycles after res_valid → outputs stable, further start and sad_valid ignored; res_ready=1 → IDLE next cycle.
- start reasserted after 500 samples, then a clean 1089-sample scan → exactly one result, reflecting only the second scan. rst mid-SCAN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/me_best_mv_tracker.sv
// Best motion-vector tracker for a serpentine full-search scan.
// Rebuilds each candidate's (x,y) from the controller move code, keeps the
// running minimum SAD and offers the winning vector on a valid/ready port.
// Optional: define ME_ZERO_BIAS_EN to break SAD ties toward the smaller
// L1 distance |mv_x|+|mv_y|.
module me_best_mv_tracker #(
  parameter int unsigned MACRO_DIM  = 16,
  parameter int unsigned SEARCH_DIM = 48,
  parameter int unsigned SAD_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_valid,
  input  logic [1:0]       sel,
  input  logic [SAD_W-1:0] sad,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [5:0]       mv_x,
  output logic [5:0]       mv_y,
  output logic [SAD_W-1:0] min_sad,
  output logic             err
);

  localparam int unsigned SPAN     = SEARCH_DIM - MACRO_DIM + 1;
  localparam int unsigned RANGE    = (SEARCH_DIM - MACRO_DIM) / 2;
  localparam int unsigned NUM_CAND = SPAN * SPAN;
  localparam int unsigned CNT_W    = $clog2(NUM_CAND + 1);
  localparam int unsigned POS_W    = 6;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic [POS_W-1:0]   best_x_q, best_x_d, best_y_q, best_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SAD_W-1:0]   best_q, best_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d, res_valid_q, res_valid_d;
  logic [POS_W-1:0]   mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic [SAD_W-1:0]   min_sad_q, min_sad_d;

  logic [POS_W-1:0]   cur_x_c, cur_y_c;
  logic               move_err_c, take_c;

`ifdef ME_ZERO_BIAS_EN
  logic [POS_W-1:0]   best_dist_q, best_dist_d;
  logic [POS_W-1:0]   dx_c, dy_c, cur_dist_c;

  // L1 distance of the candidate from the window centre
  always_comb begin
    dx_c = (cur_x_c >= POS_W'(RANGE)) ? cur_x_c - POS_W'(RANGE) : POS_W'(RANGE) - cur_x_c;
    dy_c = (cur_y_c >= POS_W'(RANGE)) ? cur_y_c - POS_W'(RANGE) : POS_W'(RANGE) - cur_y_c;
    cur_dist_c = dx_c + dy_c;
  end
`endif

  // Candidate position from the move code, saturating at the window edge
  always_comb begin
    cur_x_c    = x_q;
    cur_y_c    = y_q;
    move_err_c = 1'b0;
    if (cnt_q != '0) begin
      case (sel)
        2'd1: if (y_q == POS_W'(SPAN - 1)) move_err_c = 1'b1; else cur_y_c = y_q + POS_W'(1);
        2'd0: if (y_q == '0) move_err_c = 1'b1; else cur_y_c = y_q - POS_W'(1);
        2'd2: if (x_q == POS_W'(SPAN - 1)) move_err_c = 1'b1; else cur_x_c = x_q + POS_W'(1);
        default: move_err_c = 1'b1;
      endcase
    end
  end

  // Replace-best decision; equal SAD only wins when strictly closer to centre
  always_comb begin
`ifdef ME_ZERO_BIAS_EN
    take_c = (sad < best_q) || ((sad == best_q) && (cur_dist_c < best_dist_q));
`else
    take_c = (sad < best_q);
`endif
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    err_d       = err_q;
    mv_x_d      = mv_x_q;
    mv_y_d      = mv_y_q;
    min_sad_d   = min_sad_q;
`ifdef ME_ZERO_BIAS_EN
    best_dist_d = best_dist_q;
`endif
    if (start && (state_q != HOLD)) begin
      state_d  = SCAN;
      x_d      = '0;
      y_d      = '0;
      best_x_d = '0;
      best_y_d = '0;
      cnt_d    = '0;
      best_d   = '1;
      err_d    = 1'b0;
`ifdef ME_ZERO_BIAS_EN
      best_dist_d = '1;
`endif
    end else begin
      case (state_q)
        SCAN: begin
          if (sad_valid) begin
            x_d   = cur_x_c;
            y_d   = cur_y_c;
            err_d = err_q | move_err_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (take_c) begin
              best_d   = sad;
              best_x_d = cur_x_c;
              best_y_d = cur_y_c;
`ifdef ME_ZERO_BIAS_EN
              best_dist_d = cur_dist_c;
`endif
            end
            if (cnt_q == CNT_W'(NUM_CAND - 1)) begin
              state_d   = HOLD;
              mv_x_d    = best_x_d - POS_W'(RANGE);
              mv_y_d    = best_y_d - POS_W'(RANGE);
              min_sad_d = best_d;
            end
          end
        end
        HOLD:    if (res_ready) state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d      = (state_d == SCAN);
    res_valid_d = (state_d == HOLD);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      cnt_q       <= '0;
      best_q      <= '1;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      min_sad_q   <= '1;
`ifdef ME_ZERO_BIAS_EN
      best_dist_q <= '1;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      mv_x_q      <= mv_x_d;
      mv_y_q      <= mv_y_d;
      min_sad_q   <= min_sad_d;
`ifdef ME_ZERO_BIAS_EN
      best_dist_q <= best_dist_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign mv_x      = mv_x_q;
  assign mv_y      = mv_y_q;
  assign min_sad   = min_sad_q;
  assign err       = err_q;

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// Directed bench for me_best_mv_tracker: table of full-scan vectors plus
// hand-written sequences for errors, hold, abort and reset.
module tb_me_best_mv_tracker;

  localparam int NUM = 1089;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sad_valid = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] sad = 16'd0;
  logic        busy, res_valid;
  logic        res_ready = 1'b0;
  logic [5:0]  mv_x, mv_y;
  logic [15:0] min_sad;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  me_best_mv_tracker dut (
    .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .sel(sel),
    .sad(sad), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad), .err(err)
  );

  typedef struct {
    string name;
    int    mode;
    int    ex;
    int    ey;
    int    emin;
    int    eerr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Serpentine scan: column c climbs on even columns, descends on odd
  task automatic pos_of(input int k, output int x, output int y, output logic [1:0] s);
    int c, r;
    c = k / 33;
    r = k % 33;
    x = c;
    y = (c % 2 == 0) ? r : 32 - r;
    s = (r == 0) ? 2'd2 : ((c % 2 == 0) ? 2'd1 : 2'd0);
  endtask

  function automatic int sad_of(input int mode, input int k, input int x, input int y);
    case (mode)
      0: return (k == 0) ? 5 : 1000;
      1: return (x == 16 && y == 16) ? 0 : 1000;
      2: return ((x == 0 && y == 0) || (x == 16 && y == 16)) ? 7 : 1000;
      3: return 2000 - k;
      4: return 65535;
      5: return (k == 10) ? 1 : 1000;
      default: return 1000;
    endcase
  endfunction

  task automatic send(input logic [1:0] s, input int v);
    sad_valid = 1'b1;
    sel = s;
    sad = 16'(v);
    tick();
    sad_valid = 1'b0;
  endtask

  task automatic feed(input int mode, input int k0, input int k1);
    int x, y;
    logic [1:0] s;
    for (int k = k0; k < k1; k++) begin
      pos_of(k, x, y, s);
      if (k % 97 == 50) tick();
      send(s, sad_of(mode, k, x, y));
    end
  endtask

  // Start pulse with a bogus SAD=0 sample alongside that must be dropped
  task automatic do_start();
    start = 1'b1;
    sad_valid = 1'b1;
    sad = 16'd0;
    sel = 2'd2;
    tick();
    start = 1'b0;
    sad_valid = 1'b0;
  endtask

  task automatic check_result(input string n, input int ex, input int ey, input int emin, input int eerr);
    chk({n, ".res_valid"}, int'(res_valid), 1);
    chk({n, ".busy"}, int'(busy), 0);
    chk({n, ".mv_x"}, int'($signed(mv_x)), ex);
    chk({n, ".mv_y"}, int'($signed(mv_y)), ey);
    chk({n, ".min_sad"}, int'(min_sad), emin);
    chk({n, ".err"}, int'(err), eerr);
  endtask

  task automatic accept(input string n);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({n, ".res_valid_after_accept"}, int'(res_valid), 0);
  endtask

  initial begin
    vecs[0] = '{"cand0_min",    0, -16, -16, 5,     0};
    vecs[1] = '{"centre_min",   1,   0,   0, 0,     0};
`ifdef ME_ZERO_BIAS_EN
    vecs[2] = '{"tie",          2,   0,   0, 7,     0};
    vecs[4] = '{"all_ones",     4,   0,   0, 65535, 0};
`else
    vecs[2] = '{"tie",          2, -16, -16, 7,     0};
    vecs[4] = '{"all_ones",     4, -16, -16, 65535, 0};
`endif
    vecs[3] = '{"last_min",     3,  16,  16, 912,   0};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("reset.busy", int'(busy), 0);
    chk("reset.res_valid", int'(res_valid), 0);
    chk("reset.err", int'(err), 0);
    chk("reset.mv_x", int'(mv_x), 0);
    chk("reset.mv_y", int'(mv_y), 0);
    chk("reset.min_sad", int'(min_sad), 65535);

    // Table-driven full scans
    for (int i = 0; i < 5; i++) begin
      do_start();
      chk({vecs[i].name, ".busy_start"}, int'(busy), 1);
      feed(vecs[i].mode, 0, NUM - 1);
      chk({vecs[i].name, ".no_early_result"}, int'(res_valid), 0);
      feed(vecs[i].mode, NUM - 1, NUM);
      check_result(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].emin, vecs[i].eerr);
      accept(vecs[i].name);
    end

    // Down move at y=0 and illegal sel mid-scan: sticky err, y saturates
    do_start();
    send(2'd2, 1000);
    send(2'd0, 2);
    chk("err.after_down", int'(err), 1);
    send(2'd3, 3);
    feed(0, 1, NUM - 3);
    chk("err.no_early_result", int'(res_valid), 0);
    chk("err.still_busy", int'(busy), 1);
    feed(0, NUM - 3, NUM - 2);
    check_result("err", -16, -16, 2, 1);
    accept("err");

    // Hold result 20 cycles with start and sad_valid poking at it
    do_start();
    feed(1, 0, NUM);
    for (int c = 0; c < 20; c++) begin
      start = (c % 5 == 0);
      sad_valid = 1'b1;
      sel = 2'd2;
      sad = 16'd0;
      tick();
    end
    start = 1'b0;
    sad_valid = 1'b0;
    check_result("hold", 0, 0, 0, 0);
    accept("hold");
    chk("hold.idle_busy", int'(busy), 0);
    chk("hold.kept_mv_x", int'($signed(mv_x)), 0);
    chk("hold.kept_min_sad", int'(min_sad), 0);

    // Abort after 500 samples, then clean scan: only second scan reported
    do_start();
    feed(5, 0, 500);
    do_start();
    chk("abort.no_result", int'(res_valid), 0);
    chk("abort.busy", int'(busy), 1);
    feed(0, 0, NUM);
    check_result("abort", -16, -16, 5, 0);
    accept("abort");
    for (int c = 0; c < 5; c++) tick();
    chk("abort.single_result", int'(res_valid), 0);

    // Reset mid-scan with err set
    do_start();
    send(2'd0, 1000);
    send(2'd3, 1000);
    feed(0, 2, 300);
    chk("rst.err_pre", int'(err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.busy", int'(busy), 0);
    chk("rst.res_valid", int'(res_valid), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.mv_x", int'(mv_x), 0);
    chk("rst.mv_y", int'(mv_y), 0);
    chk("rst.min_sad", int'(min_sad), 65535);

    // Samples without start stay ignored in IDLE
    for (int c = 0; c < 3; c++) send(2'd1, 0);
    chk("idle.busy", int'(busy), 0);
    chk("idle.res_valid", int'(res_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
